mult_hilo_unit: RTL and testbench
=================================

// Module: mult_hilo_unit
// PURPOSE
//  Multi-cycle unsigned shift-add multiplier with the architectural HI/LO registers.
//  Sits downstream of the ALU control decode. Executes mul (Funct 25) and mad (Funct 1).
//  Serves mfhi/mflo reads through the 2-bit sel code (01=HI, 10=LO).
//  Stalls the pipeline when HI/LO is read while a multiply is still in flight.
// PARAMETERS
//  WIDTH   32   operand width; product and HI:LO pair are 2*WIDTH bits
// PORTS
//  clk         in   1        single clock; all state on rising edge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        1-cycle request; operands and mad sampled with it
//  mad         in   1        1 = accumulate into {HI,LO}; 0 = overwrite
//  a           in   WIDTH    multiplicand (unsigned)
//  b           in   WIDTH    multiplier (unsigned)
//  sel         in   2        01 = read HI, 10 = read LO, 00/11 = no read
//  result_out  out  WIDTH    HI if sel=01, LO if sel=10, else 0 (combinational)
//  hi          out  WIDTH    committed HI register
//  lo          out  WIDTH    committed LO register
//  busy        out  1        high whenever state != IDLE
//  done        out  1        1-cycle pulse in the cycle HI/LO are updated
//  stall       out  1        busy & (sel==01 | sel==10), combinational
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, hi=lo=0, count=0, busy=0, done=0; internal regs cleared.
//  FSM IDLE -> RUN -> WRITE -> IDLE.
//   IDLE: start=1 latches a->mcand, b->mplier, mad->mad_q; prod=0, count=0; go RUN.
//   RUN: one iteration per cycle.
//    - If mplier[0], prod[2W-1:W] += mcand, carry kept in a (W+1)-bit add.
//    - Then {carry,prod} >>= 1 and mplier >>= 1; count++.
//    - After iteration WIDTH-1, go WRITE.
//   WRITE: {hi,lo} = mad_q ? {hi,lo}+prod (mod 2^(2W)) : prod; done=1; go IDLE.
//  Latency: start sampled at edge 0; hi/lo and done visible after edge WIDTH+1 (33 for W=32).
//  start while busy (RUN or WRITE) is ignored, with no queueing; start is accepted only in IDLE.
//  Operands a/b/mad may change after the start cycle without effect.
//  result_out/hi/lo always show committed values.
//   - An in-flight product never appears early.
//   - stall holds the reader until done; the first unstalled read sees the new value.
//  sel=11 yields result_out=0 and no stall.
//  Reset mid-operation aborts: no write, hi/lo=0, done never pulses.
//  mad overflow beyond 2*WIDTH bits is discarded silently (wrap-around).
//  count width = $clog2(WIDTH); no X on any output after reset.
// STRUCTURE
//  Shared package mips_pkg holds the shared constants:
//   - ALU op codes (ALU_mul=3'b100, etc.).
//   - Funct codes F_mul=6'd25, F_mad=6'd1, F_mfhi=6'd16, F_mflo=6'd18.
//   - sel codes SEL_NONE=2'b00, SEL_HI=2'b01, SEL_LO=2'b10.
//   - FSM state enum {IDLE,RUN,WRITE}.
//  Sub-module mult_shift_add_core holds mcand/mplier/prod/count and the iteration.
//  The top module keeps the FSM, HI/LO, accumulate adder, and read mux/stall.
// TESTING
//  1. Reset, start a=3,b=5,mad=0 -> done after 33 edges; hi=0, lo=15; busy low next cycle.
//  2. a=FFFFFFFF, b=FFFFFFFF, mad=0 -> hi=FFFFFFFE, lo=00000001.
//  3. From hi=0,lo=15: start a=2,b=3,mad=1 -> hi=0, lo=21.
//  4. Accumulate wrap: hi=lo=FFFFFFFF, mad 1*1 -> hi=0, lo=0.
//  5. sel=01 during RUN -> stall=1 and result_out=old hi; stall drops after done; result_out=new hi.
//  6. Second start at cycle 10 of run is ignored (single done).
//  7. rst at cycle 10 of a run -> hi=lo=0, busy=0 immediately, no done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath slice: ALU ops, funct codes,
// HI/LO read-select codes and the multiplier FSM states.
package mips_pkg;

  localparam logic [2:0] ALU_and = 3'b000;
  localparam logic [2:0] ALU_or  = 3'b001;
  localparam logic [2:0] ALU_add = 3'b010;
  localparam logic [2:0] ALU_mul = 3'b100;
  localparam logic [2:0] ALU_sub = 3'b110;
  localparam logic [2:0] ALU_slt = 3'b111;

  localparam logic [5:0] F_mad  = 6'd1;
  localparam logic [5:0] F_mfhi = 6'd16;
  localparam logic [5:0] F_mflo = 6'd18;
  localparam logic [5:0] F_mul  = 6'd25;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HI   = 2'b01;
  localparam logic [1:0] SEL_LO   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiplier.
interface mult_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mad;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] result_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, mad, a, b, sel,
    input  result_out, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, mad, a, b, sel,
    output result_out, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_shift_add_core.sv
// Unsigned shift-add multiplier datapath: one multiplier bit retired per step.
module mult_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      prod_d   = '0;
      count_d  = '0;
    end else if (step_i) begin
      // Carry-out of the upper-half add becomes the new MSB after the shift.
      prod_d   = {sum, prod_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
    end
  end

  assign prod_o = prod_q;
  assign last_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle mul/mad unit owning the architectural HI/LO pair, with
// mfhi/mflo read mux and a stall when HI/LO is read mid-multiply.
module mult_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mult_hilo_unit_if.slave  mh_if
);
  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               mad_q;
  logic               done_q;
  logic               load, step, last;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] acc;
  logic               rd_sel;

  assign load = (state_q == IDLE) && mh_if.start;
  assign step = (state_q == RUN);

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .a_i    (mh_if.a),
    .b_i    (mh_if.b),
    .prod_o (prod),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mh_if.start) state_d = RUN;
      RUN:     if (last) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulation wraps modulo 2^(2*WIDTH); the carry-out is dropped.
  assign acc = {hi_q, lo_q} + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == WRITE);
      if (load) mad_q <= mh_if.mad;
      if (state_q == WRITE) {hi_q, lo_q} <= mad_q ? acc : prod;
    end
  end

  assign rd_sel           = (mh_if.sel == SEL_HI) || (mh_if.sel == SEL_LO);
  assign mh_if.result_out = (mh_if.sel == SEL_HI) ? hi_q :
                            (mh_if.sel == SEL_LO) ? lo_q : '0;
  assign mh_if.hi         = hi_q;
  assign mh_if.lo         = lo_q;
  assign mh_if.busy       = (state_q != IDLE);
  assign mh_if.done       = done_q;
  assign mh_if.stall      = (state_q != IDLE) && rd_sel;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Randomised self-checking bench for mult_hilo_unit against a latency/arithmetic model.
module tb_mult_hilo_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_hilo_unit_if #(.WIDTH(W)) mh ();
  mult_hilo_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mh_if(mh.slave));

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  // Model: an accepted op commits (old*mad + a*b) mod 2^64 exactly W+1 edges later.
  logic [63:0] m_hilo;
  int          m_pend;
  bit          m_done;
  logic [31:0] m_a, m_b;
  bit          m_mad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hilo = 64'd0; m_pend = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_hilo = (m_mad ? m_hilo : 64'd0) + 64'(m_a) * 64'(m_b);
          m_done = 1'b1;
        end
      end else if (mh.start) begin
        m_a = mh.a; m_b = mh.b; m_mad = mh.mad; m_pend = W + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_busy;
      logic [31:0] e_res;
      e_busy = (m_pend > 0);
      e_res  = (mh.sel == 2'b01) ? m_hilo[63:32] : (mh.sel == 2'b10) ? m_hilo[31:0] : 32'd0;
      chk("busy", 64'(mh.busy), 64'(e_busy));
      chk("done", 64'(mh.done), 64'(m_done));
      chk("hi", 64'(mh.hi), 64'(m_hilo[63:32]));
      chk("lo", 64'(mh.lo), 64'(m_hilo[31:0]));
      chk("stall", 64'(mh.stall), 64'(e_busy && (mh.sel == 2'b01 || mh.sel == 2'b10)));
      chk("result_out", 64'(mh.result_out), 64'(e_res));
      if (mh.done === 1'b1) done_seen++;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit mad);
    mh.start = 1'b1; mh.a = a; mh.b = b; mh.mad = mad;
    tick();
    mh.start = 1'b0; mh.a = $urandom; mh.b = $urandom; mh.mad = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mh.done === 1'b1) begin
        lat = i + 1;
        #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_done timeout actual=no_done required=done");
  endtask

  initial begin
    int lat, d0;
    rst = 1'b1;
    mh.start = 1'b0; mh.mad = 1'b0; mh.a = '0; mh.b = '0; mh.sel = 2'b00;
    repeat (3) tick();
    chk("rst_hi", 64'(mh.hi), 64'd0);
    chk("rst_lo", 64'(mh.lo), 64'd0);
    chk("rst_busy", 64'(mh.busy), 64'd0);
    chk("rst_done", 64'(mh.done), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    start_op(32'd3, 32'd5, 1'b0);
    wait_done(lat);
    chk("t1_latency", 64'(lat), 64'd33);
    chk("t1_hi", 64'(mh.hi), 64'd0);
    chk("t1_lo", 64'(mh.lo), 64'd15);
    tick();
    chk("t1_busy_after", 64'(mh.busy), 64'd0);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat);
    chk("t2_hi", 64'(mh.hi), 64'hFFFF_FFFE);
    chk("t2_lo", 64'(mh.lo), 64'h0000_0001);

    start_op(32'd3, 32'd5, 1'b0);
    wait_done(lat);
    start_op(32'd2, 32'd3, 1'b1);
    wait_done(lat);
    chk("t3_hi", 64'(mh.hi), 64'd0);
    chk("t3_lo", 64'(mh.lo), 64'd21);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done(lat);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b1);         wait_done(lat);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b1);         wait_done(lat);
    chk("t4_pre_hi", 64'(mh.hi), 64'hFFFF_FFFF);
    chk("t4_pre_lo", 64'(mh.lo), 64'hFFFF_FFFF);
    start_op(32'd1, 32'd1, 1'b1);
    wait_done(lat);
    chk("t4_wrap_hi", 64'(mh.hi), 64'd0);
    chk("t4_wrap_lo", 64'(mh.lo), 64'd0);

    mh.sel = 2'b01;
    start_op(32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("t5_stall", 64'(mh.stall), 64'd1);
    chk("t5_old_hi", 64'(mh.result_out), 64'd0);
    wait_done(lat);
    chk("t5_unstall", 64'(mh.stall), 64'd0);
    chk("t5_new_hi", 64'(mh.result_out), 64'd1);
    mh.sel = 2'b11;
    tick();
    chk("t5_sel11_res", 64'(mh.result_out), 64'd0);
    mh.sel = 2'b00;

    d0 = done_seen;
    start_op(32'd5, 32'd7, 1'b0);
    repeat (8) tick();
    start_op(32'd9, 32'd9, 1'b0);
    wait_done(lat);
    repeat (40) tick();
    chk("t6_single_done", 64'(done_seen - d0), 64'd1);
    chk("t6_lo", 64'(mh.lo), 64'd35);

    d0 = done_seen;
    start_op(32'd6, 32'd6, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("t7_hi", 64'(mh.hi), 64'd0);
    chk("t7_lo", 64'(mh.lo), 64'd0);
    chk("t7_busy", 64'(mh.busy), 64'd0);
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("t7_no_done", 64'(done_seen - d0), 64'd0);

    repeat (30) begin
      int n;
      mh.sel = 2'($urandom_range(0, 3));
      start_op($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
               1'($urandom_range(0, 1)));
      n = $urandom_range(20, 45);
      for (int k = 0; k < n; k++) begin
        mh.start = ($urandom_range(0, 7) == 0);
        mh.a = $urandom; mh.b = $urandom; mh.mad = 1'($urandom_range(0, 1));
        mh.sel = 2'($urandom_range(0, 3));
        tick();
      end
      mh.start = 1'b0;
    end
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
